// File: rtl/regfile_pkg.sv
// Shared encodings and the write-merge helper for the regfile_mp register file.
package regfile_pkg;

    // Write size encodings; the fourth code (3) behaves as a word write.
    localparam logic [1:0] WS_BYTE = 2'd0;
    localparam logic [1:0] WS_HALF = 2'd1;
    localparam logic [1:0] WS_WORD = 2'd2;

    // Widest register the merge helper handles; callers zero-extend into it
    // and truncate the result back to their own width.
    localparam int REG_MAX_W = 1024;

    // Merge a write into the old register contents: byte and half writes
    // touch only the low bits, anything else replaces the whole value.
    function automatic logic [REG_MAX_W-1:0] merge_write(
        input logic [REG_MAX_W-1:0] old_val,
        input logic [REG_MAX_W-1:0] new_val,
        input logic [1:0]           size
    );
        logic [REG_MAX_W-1:0] res;
        res = old_val;
        case (size)
            WS_BYTE: res[7:0]  = new_val[7:0];
            WS_HALF: res[15:0] = new_val[15:0];
            default: res       = new_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one bit per register, set by reserve, cleared by
// write, set wins on a same-address collision; register 0 optionally masked.
module regfile_scoreboard #(
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   set_en,
    input  logic [ADDR_W-1:0]      set_addr,
    input  logic                   clr_en,
    input  logic [ADDR_W-1:0]      clr_addr,
    output logic [(1<<ADDR_W)-1:0] busy_vec
);

    localparam int NREG = 1 << ADDR_W;

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_nxt;

    // Next busy state: clear first so a same-address set takes priority.
    always_comb begin
        busy_nxt = busy_q;
        if (clr_en) busy_nxt[clr_addr] = 1'b0;
        if (set_en) busy_nxt[set_addr] = 1'b1;
        if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
    end

    // Busy state register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_nxt;
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with masked writes and a busy scoreboard.
// Optional macro REGFILE_BYPASS_EN: forward a same-edge write (data and
// post-update busy) to a read of the same address.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREAD-1:0]        rd_en,
    input  logic [NREAD*ADDR_W-1:0] rd_addr,
    output logic [NREAD*DATA_W-1:0] rd_data,
    output logic [NREAD-1:0]        rd_busy,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [1:0]              wr_size,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    rsv_en,
    input  logic [ADDR_W-1:0]       rsv_addr,
    output logic [(1<<ADDR_W)-1:0]  busy_vec
);

    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0]       regs [NREG];
    logic                    wr_ok;
    logic [DATA_W-1:0]       wr_merged;
    logic [DATA_W-1:0]       rd_data_nxt [NREAD];
    logic [NREAD-1:0]        rd_busy_nxt;
    logic [NREAD*DATA_W-1:0] rd_data_p1;
    logic [NREAD-1:0]        rd_busy_p1;
`ifdef REGFILE_BYPASS_EN
    logic                    rsv_ok;
`endif

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (rsv_en),
        .set_addr (rsv_addr),
        .clr_en   (wr_en),
        .clr_addr (wr_addr),
        .busy_vec (busy_vec)
    );

    // Write qualification and merged write value (zero register drops writes).
    always_comb begin
        wr_ok     = wr_en && !(ZERO_REG != 0 && wr_addr == '0);
        wr_merged = DATA_W'(merge_write(REG_MAX_W'(regs[wr_addr]),
                                        REG_MAX_W'(wr_data), wr_size));
`ifdef REGFILE_BYPASS_EN
        rsv_ok    = rsv_en && !(ZERO_REG != 0 && rsv_addr == '0);
`endif
    end

    // Per-port read selection, with same-edge forwarding when enabled.
    always_comb begin
        rd_busy_nxt = '0;
        for (int i = 0; i < NREAD; i++) begin
`ifdef REGFILE_BYPASS_EN
            rd_data_nxt[i] = (wr_ok && wr_addr == rd_addr[i*ADDR_W +: ADDR_W])
                             ? wr_merged : regs[rd_addr[i*ADDR_W +: ADDR_W]];
            rd_busy_nxt[i] = (rsv_ok && rsv_addr == rd_addr[i*ADDR_W +: ADDR_W]) ||
                             (busy_vec[rd_addr[i*ADDR_W +: ADDR_W]] &&
                              !(wr_ok && wr_addr == rd_addr[i*ADDR_W +: ADDR_W]));
`else
            rd_data_nxt[i] = regs[rd_addr[i*ADDR_W +: ADDR_W]];
            rd_busy_nxt[i] = busy_vec[rd_addr[i*ADDR_W +: ADDR_W]];
`endif
        end
    end

    // Data array: asynchronous clear, masked write on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) regs[r] <= '0;
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_merged;
        end
    end

    // ---- read stage p1: registered outputs, held while a port is disabled ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_p1 <= '0;
            rd_busy_p1 <= '0;
        end else begin
            for (int i = 0; i < NREAD; i++) begin
                if (rd_en[i]) begin
                    rd_data_p1[i*DATA_W +: DATA_W] <= rd_data_nxt[i];
                    rd_busy_p1[i]                  <= rd_busy_nxt[i];
                end
            end
        end
    end

    assign rd_data = rd_data_p1;
    assign rd_busy = rd_busy_p1;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (DATA_W=32, ADDR_W=5, NREAD=2,
// ZERO_REG=1); covers both builds of REGFILE_BYPASS_EN.
module tb_regfile_mp;

    logic        clk;
    logic        rst_n;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [1:0]  wr_size;
    logic [31:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic [31:0] busy_vec;

    int total;
    int bad;

    regfile_mp #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .NREAD    (2),
        .ZERO_REG (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_size  (wr_size),
        .wr_data  (wr_data),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .busy_vec (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [4:0] a, input logic [1:0] sz, input logic [31:0] d,
                         input logic rsv);
        wr_en = 1'b1; wr_addr = a; wr_size = sz; wr_data = d;
        rsv_en = rsv; rsv_addr = a;
        tick();
        wr_en = 1'b0; rsv_en = 1'b0;
    endtask

    task automatic read2(input logic [4:0] a0, input logic [4:0] a1);
        rd_en = 2'b11; rd_addr = {a1, a0};
        tick();
        rd_en = 2'b00;
    endtask

    task automatic check_ports(input string tag, input logic [31:0] d0, input logic b0,
                               input logic [31:0] d1, input logic b1);
        check({tag, "_d0"}, 64'(rd_data[31:0]),  64'(d0));
        check({tag, "_b0"}, 64'(rd_busy[0]),     64'(b0));
        check({tag, "_d1"}, 64'(rd_data[63:32]), 64'(d1));
        check({tag, "_b1"}, 64'(rd_busy[1]),     64'(b1));
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b1; rd_en = '0; rd_addr = '0;
        wr_en = 1'b0; wr_addr = '0; wr_size = '0; wr_data = '0;
        rsv_en = 1'b0; rsv_addr = '0;

        // Reset state
        #2 rst_n = 1'b0;
        repeat (2) tick();
        check("rst_rd_data", rd_data, 64'h0);
        check("rst_rd_busy", 64'(rd_busy), 64'h0);
        check("rst_busy_vec", 64'(busy_vec), 64'h0);
        #3 rst_n = 1'b1;

        // Every address reads zero and not busy after reset
        for (int a = 0; a < 32; a++) begin
            read2(5'(a), 5'(a));
            check_ports($sformatf("rst_read_%0d", a), 32'h0, 1'b0, 32'h0, 1'b0);
        end
        check("rst_busy_vec_after", 64'(busy_vec), 64'h0);

        // Byte and half merges on reg 5; upper input bits must be ignored
        write(5'd5, 2'd2, 32'hAABBCCDD, 1'b0);
        write(5'd5, 2'd0, 32'hFFFFFF11, 1'b0);
        read2(5'd5, 5'd5);
        check_ports("byte_merge", 32'hAABBCC11, 1'b0, 32'hAABBCC11, 1'b0);
        write(5'd5, 2'd1, 32'h55552233, 1'b0);
        read2(5'd5, 5'd5);
        check_ports("half_merge", 32'hAABB2233, 1'b0, 32'hAABB2233, 1'b0);

        // Zero register ignores write and reserve
        write(5'd0, 2'd2, 32'hFFFFFFFF, 1'b1);
        check("zero_busy_vec", 64'(busy_vec), 64'h0);
        read2(5'd0, 5'd0);
        check_ports("zero_reg", 32'h0, 1'b0, 32'h0, 1'b0);

        // Reservation tracking on reg 7
        rsv_en = 1'b1; rsv_addr = 5'd7;
        tick();
        rsv_en = 1'b0;
        check("rsv7_busy_vec", 64'(busy_vec), 64'h80);
        read2(5'd7, 5'd7);
        check_ports("rsv7_read", 32'h0, 1'b1, 32'h0, 1'b1);
        write(5'd7, 2'd2, 32'hDEAD0000, 1'b1);
        check("rsv_wr7_busy_vec", 64'(busy_vec), 64'h80);
        read2(5'd7, 5'd7);
        check_ports("rsv_wr7_read", 32'hDEAD0000, 1'b1, 32'hDEAD0000, 1'b1);
        write(5'd7, 2'd2, 32'h00001234, 1'b0);
        check("wr7_busy_vec", 64'(busy_vec), 64'h0);
        read2(5'd7, 5'd7);
        check_ports("wr7_read", 32'h00001234, 1'b0, 32'h00001234, 1'b0);

        // Size code 3 acts as a full word
        write(5'd10, 2'd3, 32'h89ABCDEF, 1'b0);
        read2(5'd10, 5'd10);
        check_ports("size3", 32'h89ABCDEF, 1'b0, 32'h89ABCDEF, 1'b0);

        // Reg 9 = 0 and busy, then same-edge write+read on port 1; port 0 held
        write(5'd9, 2'd2, 32'h0, 1'b1);
        check("rsv9_busy_vec", 64'(busy_vec), 64'h200);
        wr_en = 1'b1; wr_addr = 5'd9; wr_size = 2'd2; wr_data = 32'hCAFE0001;
        rd_en = 2'b10; rd_addr = {5'd9, 5'd5};
        tick();
        wr_en = 1'b0; rd_en = 2'b00;
`ifdef REGFILE_BYPASS_EN
        check_ports("same_edge", 32'h89ABCDEF, 1'b0, 32'hCAFE0001, 1'b0);
`else
        check_ports("same_edge", 32'h89ABCDEF, 1'b0, 32'h0, 1'b1);
`endif
        check("same_edge_busy_vec", 64'(busy_vec), 64'h0);
        read2(5'd9, 5'd9);
        check_ports("after_same_edge", 32'hCAFE0001, 1'b0, 32'hCAFE0001, 1'b0);

        // Asynchronous reset mid-stream
        rsv_en = 1'b1; rsv_addr = 5'd12;
        tick();
        rsv_en = 1'b0;
        read2(5'd5, 5'd12);
        check_ports("pre_reset", 32'hAABB2233, 1'b0, 32'h0, 1'b1);
        check("pre_reset_busy_vec", 64'(busy_vec), 64'h1000);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_rd_data", rd_data, 64'h0);
        check("async_rst_rd_busy", 64'(rd_busy), 64'h0);
        check("async_rst_busy_vec", 64'(busy_vec), 64'h0);
        #2 rst_n = 1'b1;
        read2(5'd5, 5'd9);
        check_ports("post_reset", 32'h0, 1'b0, 32'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
